// File: rtl/fifo_bulk_reader_pkg.sv
// Shared definitions for the bulk FIFO reader: FSM encoding and skid buffer depth.
package fifo_bulk_reader_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBurst = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_bulk_reader_skid_buffer.sv
// Two-entry valid/ready buffer. The head entry drives the output; the upstream side has
// no ready and relies on the producer's credit accounting to never push into a full buffer.
module stream_skid_buffer #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             pop;

  always_comb begin
    pop     = (count_q != 2'd0) && out_ready;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({in_valid, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_data;
        else                 tail_d = in_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push and pop keeps occupancy; the new word lands behind any survivor.
        if (count_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign count     = count_q;

endmodule

// File: rtl/fifo_bulk_reader.sv
// Reads one full bulk from the FIFO and emits it as a single stream packet with tlast,
// throttling FIFO reads so the output skid buffer can absorb any backpressure pattern.
module fifo_bulk_reader
  import fifo_bulk_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BULK_OF_DATA = 8,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_r_ready,
  input  logic                  fifo_error_empty,
  output logic                  fifo_r_enable,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic                  busy,
  output logic                  underrun,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  localparam logic [CNT_WIDTH-1:0] LastIdx = CNT_WIDTH'(BULK_OF_DATA - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
  logic                 r_en_q, r_en_d;
  logic                 underrun_q, underrun_d;

  logic                  sk_valid;
  logic [DATA_WIDTH:0]   sk_data;
  logic [1:0]            sk_count;
  logic                  pop;
  logic [2:0]            occ_next;
  logic                  credit_ok;

  assign pop = sk_valid && m_tready;

  // Occupancy after this edge plus the read being issued must fit in the buffer.
  assign occ_next  = 3'(sk_count) + 3'(r_en_q) - 3'(pop);
  assign credit_ok = occ_next < 3'(SKID_DEPTH);

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    beat_d     = beat_q + CNT_WIDTH'(r_en_q);
    pkt_d      = pkt_q;
    r_en_d     = 1'b0;
    underrun_d = underrun_q;
    unique case (state_q)
      StIdle: begin
        if (enable && fifo_r_ready && !fifo_error_empty) begin
          state_d  = StBurst;
          issued_d = '0;
          beat_d   = '0;
        end
      end
      StBurst: begin
        if (credit_ok) begin
          r_en_d   = 1'b1;
          issued_d = issued_q + 1'b1;
          if (fifo_error_empty) underrun_d = 1'b1;
          if (issued_q == LastIdx) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && sk_data[DATA_WIDTH]) begin
          pkt_d   = pkt_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      issued_q   <= '0;
      beat_q     <= '0;
      pkt_q      <= '0;
      r_en_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      beat_q     <= beat_d;
      pkt_q      <= pkt_d;
      r_en_q     <= r_en_d;
      underrun_q <= underrun_d;
    end
  end

  stream_skid_buffer #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (r_en_q),
    .in_data   ({beat_q == LastIdx, fifo_rdata}),
    .out_valid (sk_valid),
    .out_data  (sk_data),
    .out_ready (m_tready),
    .count     (sk_count)
  );

  assign fifo_r_enable = r_en_q;
  assign m_tvalid      = sk_valid;
  assign m_tdata       = sk_data[DATA_WIDTH-1:0];
  assign m_tlast       = sk_data[DATA_WIDTH];
  assign busy          = (state_q != StIdle);
  assign underrun      = underrun_q;
  assign pkt_count     = pkt_q;

endmodule
